// File: rtl/tx_word_packer.sv
// Byte-to-32-bit word packer feeding the PC transmit path, first byte in [31:24].
// Define TX_PACKER_TIMEOUT_EN to auto-flush a partial word after TIMEOUT_CLKS idle clocks.
module tx_word_packer #(
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_byte_data,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_flush,
  input  logic        i_hold,
  output logic [31:0] o_word_data,
  output logic        o_word_write,
  output logic [1:0]  o_fill_count,
  output logic [15:0] o_words_sent
);

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] sent_q, sent_d;
  logic [2:0]  fill_after;
  logic        accept;
  logic        timeout_hit;

`ifdef TX_PACKER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);

  logic [15:0] timer_q, timer_d;

  // Idle timer only counts while a partial word sits in FILL with no byte or flush.
  always_comb begin
    timer_d     = '0;
    timeout_hit = 1'b0;
    if (state_q == FILL && count_q != 2'd0 && !i_byte_valid) begin
      if (timer_q == TIMEOUT_LAST) begin
        timeout_hit = 1'b1;
      end else if (!i_flush) begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CLKS);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state, lane packing and handshake outputs.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    count_d      = count_q;
    sent_d       = sent_q;
    accept       = 1'b0;
    fill_after   = {1'b0, count_q};
    o_byte_ready = (state_q == FILL) && !i_reset;
    o_word_write = (state_q == PENDING) && !i_hold && !i_reset;

    case (state_q)
      FILL: begin
        accept = i_byte_valid;
        if (accept) begin
          fill_after = {1'b0, count_q} + 3'd1;
          case (count_q)
            2'd0:    word_d[31:24] = i_byte_data;
            2'd1:    word_d[23:16] = i_byte_data;
            2'd2:    word_d[15:8]  = i_byte_data;
            default: word_d[7:0]   = i_byte_data;
          endcase
        end

        if (fill_after == 3'd4) begin
          state_d = PENDING;
          count_d = 2'd0;
        end else if ((i_flush || timeout_hit) && fill_after != 3'd0) begin
          // Lanes at or beyond the fill point get the pad byte.
          for (int l = 1; l < 4; l++) begin
            if (3'(l) >= fill_after) begin
              word_d[31-8*l -: 8] = PAD_BYTE;
            end
          end
          state_d = PENDING;
          count_d = 2'd0;
        end else begin
          count_d = fill_after[1:0];
        end
      end

      PENDING: begin
        if (!i_hold) begin
          state_d = FILL;
          sent_d  = sent_q + 16'd1;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= FILL;
      word_q  <= '0;
      count_q <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      sent_q  <= sent_d;
    end
  end

  assign o_word_data  = word_q;
  assign o_fill_count = count_q;
  assign o_words_sent = sent_q;

endmodule

// File: tb/tb_tx_word_packer.sv
// Directed bench for tx_word_packer with hand-computed expectations.
// The timeout section is active only when TX_PACKER_TIMEOUT_EN is defined.
module tb_tx_word_packer;

`ifdef TX_PACKER_TIMEOUT_EN
  localparam int unsigned TO_CLKS = 10;
`else
  localparam int unsigned TO_CLKS = 50000;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [7:0]  i_byte_data;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        i_flush;
  logic        i_hold;
  logic [31:0] o_word_data;
  logic        o_word_write;
  logic [1:0]  o_fill_count;
  logic [15:0] o_words_sent;

  int n_cmp = 0;
  int n_err = 0;

  tx_word_packer #(
    .PAD_BYTE    (8'h00),
    .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_byte_data (i_byte_data),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .i_flush     (i_flush),
    .i_hold      (i_hold),
    .o_word_data (o_word_data),
    .o_word_write(o_word_write),
    .o_fill_count(o_fill_count),
    .o_words_sent(o_words_sent)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    tick();
    i_byte_valid = 1'b0;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_byte_data  = 8'h00;
    i_byte_valid = 1'b0;
    i_flush      = 1'b0;
    i_hold       = 1'b0;

    // Reset state
    tick();
    tick();
    settle();
    check("rst_ready", 32'(o_byte_ready), 32'd0);
    check("rst_write", 32'(o_word_write), 32'd0);
    i_reset = 1'b0;
    settle();
    check("post_rst_ready", 32'(o_byte_ready), 32'd1);
    check("post_rst_fill", 32'(o_fill_count), 32'd0);
    check("post_rst_sent", 32'(o_words_sent), 32'd0);
    check("post_rst_data", o_word_data, 32'h0);

    // Full word DEADBEEF, no hold
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    settle();
    check("w1_write", 32'(o_word_write), 32'd1);
    check("w1_data", o_word_data, 32'hDEADBEEF);
    check("w1_ready", 32'(o_byte_ready), 32'd0);
    check("w1_fill", 32'(o_fill_count), 32'd0);
    tick();
    settle();
    check("w1_write_after", 32'(o_word_write), 32'd0);
    check("w1_sent", 32'(o_words_sent), 32'd1);
    check("w1_ready_after", 32'(o_byte_ready), 32'd1);

    // Partial word flush with padding
    send_byte(8'h11);
    send_byte(8'h22);
    settle();
    check("p2_fill", 32'(o_fill_count), 32'd2);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    settle();
    check("p2_write", 32'(o_word_write), 32'd1);
    check("p2_data", o_word_data, 32'h11220000);
    tick();
    settle();
    check("p2_sent", 32'(o_words_sent), 32'd2);

    // Flush with empty word is a no-op
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    settle();
    check("empty_flush_write", 32'(o_word_write), 32'd0);
    check("empty_flush_ready", 32'(o_byte_ready), 32'd1);
    check("empty_flush_sent", 32'(o_words_sent), 32'd2);

    // Hold blocks emission for 20 cycles
    i_hold = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    for (int i = 0; i < 20; i++) begin
      settle();
      check("hold_write", 32'(o_word_write), 32'd0);
      check("hold_ready", 32'(o_byte_ready), 32'd0);
      tick();
    end
    i_hold = 1'b0;
    settle();
    check("hold_rel_write", 32'(o_word_write), 32'd1);
    check("hold_rel_data", o_word_data, 32'h01020304);
    tick();
    settle();
    check("hold_rel_write_after", 32'(o_word_write), 32'd0);
    check("hold_rel_sent", 32'(o_words_sent), 32'd3);
    send_byte(8'h55);
    settle();
    check("resume_fill", 32'(o_fill_count), 32'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    settle();
    check("resume_data", o_word_data, 32'h55000000);
    check("resume_write", 32'(o_word_write), 32'd1);
    tick();

    // Byte plus flush completing a word: no padding
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    settle();
    check("bf_fill", 32'(o_fill_count), 32'd3);
    i_flush = 1'b1;
    send_byte(8'h44);
    i_flush = 1'b0;
    settle();
    check("bf_write", 32'(o_word_write), 32'd1);
    check("bf_data", o_word_data, 32'h11223344);
    tick();
    settle();
    check("bf_single_strobe", 32'(o_word_write), 32'd0);
    check("bf_sent", 32'(o_words_sent), 32'd5);

    // Byte plus flush on an empty word: one byte and three pads
    i_flush = 1'b1;
    send_byte(8'h77);
    i_flush = 1'b0;
    settle();
    check("bfe_data", o_word_data, 32'h77000000);
    check("bfe_write", 32'(o_word_write), 32'd1);
    tick();
    settle();
    check("bfe_sent", 32'(o_words_sent), 32'd6);

    // Flush while pending is ignored
    i_hold = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    settle();
    check("pend_flush_data", o_word_data, 32'hA1A2A3A4);
    check("pend_flush_write", 32'(o_word_write), 32'd0);
    check("pend_flush_ready", 32'(o_byte_ready), 32'd0);

    // Reset while pending with hold discards the word
    i_reset = 1'b1;
    settle();
    check("rst_pend_write", 32'(o_word_write), 32'd0);
    tick();
    i_hold = 1'b0;
    settle();
    check("rst_pend_write2", 32'(o_word_write), 32'd0);
    check("rst_pend_ready", 32'(o_byte_ready), 32'd0);
    i_reset = 1'b0;
    settle();
    check("rst_rel_ready", 32'(o_byte_ready), 32'd1);
    check("rst_rel_fill", 32'(o_fill_count), 32'd0);
    check("rst_rel_sent", 32'(o_words_sent), 32'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_rel_no_strobe", 32'(o_word_write), 32'd0);
      tick();
    end

`ifdef TX_PACKER_TIMEOUT_EN
    // Idle timeout flushes after TIMEOUT_CLKS clocks
    send_byte(8'hA5);
    for (int i = 1; i < 10; i++) begin
      tick();
      settle();
      check("to_wait_write", 32'(o_word_write), 32'd0);
    end
    tick();
    settle();
    check("to_write", 32'(o_word_write), 32'd1);
    check("to_data", o_word_data, 32'hA5000000);
    tick();
    settle();
    check("to_sent", 32'(o_words_sent), 32'd1);

    // A byte at cycle 9 restarts the timer
    send_byte(8'hB6);
    for (int i = 1; i < 9; i++) begin
      tick();
    end
    send_byte(8'hC7);
    settle();
    check("to_restart_fill", 32'(o_fill_count), 32'd2);
    tick();
    settle();
    check("to_restart_write", 32'(o_word_write), 32'd0);
    check("to_restart_fill2", 32'(o_fill_count), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_word_packer.md
Name: tx_word_packer

Overview:
Upstream feeder for the PC transmit path. Collects a byte stream from the design (status, readback, debug) and packs it into 32-bit words. Each word is presented with a single-cycle write strobe, wired directly to the PC transmit block's word-data and word-write-command inputs. Partial words are padded and pushed out on an explicit flush, or on an idle timeout when that feature is compiled in.

Parameters:
PAD_BYTE, 8'h00, filler byte used for unused lanes of a flushed partial word
TIMEOUT_CLKS, 50000, idle clocks (1 ms at 50 MHz) before a partial word auto-flushes; legal range 1..65535; only used with TX_PACKER_TIMEOUT_EN

Ports:
i_clock  in  1  system clock (50 MHz)
i_reset  in  1  synchronous reset, active-high
i_byte_data  in  8  byte to pack
i_byte_valid  in  1  byte offered this cycle; accepted when o_byte_ready=1
o_byte_ready  out  1  packer can accept a byte this cycle
i_flush  in  1  single-cycle request: pad and emit any partial word
i_hold  in  1  downstream busy (tie to PC transmit active flag); blocks emission
o_word_data  out  32  packed word; valid while o_word_write=1
o_word_write  out  1  one-cycle write strobe to the downstream FIFO
o_fill_count  out  2  bytes currently held in the partial word (0..3)
o_words_sent  out  16  count of emitted words; wraps 65535->0

Behaviour:
- One clock; all state updates on rising i_clock. i_reset is sampled synchronously and overrides all other inputs.
- Reset values:
  - state=FILL; o_word_data=0; o_word_write=0; o_fill_count=0; o_words_sent=0; idle timer=0.
  - o_byte_ready=0 while i_reset=1, and 1 in the first cycle after reset.
- Byte lanes: the first byte of a word goes to [31:24], then [23:16], [15:8]; the fourth byte goes to [7:0].
- State FILL:
  - o_byte_ready=1.
  - Accept a byte when i_byte_valid=1 and increment the lane count.
  - On the 4th accepted byte, latch the word and move to PENDING at the same edge.
- State PENDING:
  - o_byte_ready=0; bytes offered are not accepted, and the source must hold them.
  - o_word_write = (state==PENDING && i_hold==0), combinational from registered state.
  - At the edge where o_word_write=1: return to FILL, clear the lane count, o_words_sent+1.
  - o_word_write is therefore high for exactly one cycle per word.
- Latency: the 4th byte accepted at edge N gives o_word_write=1 in the cycle after N when i_hold=0. Otherwise the strobe stays low until the first cycle with i_hold=0; o_word_data is stable throughout.
- Flush, in FILL:
  - i_flush=1 with lane count 0 and no byte accepted: no-op, nothing emitted.
  - With 1..3 bytes held, remaining lanes are filled with PAD_BYTE and the block moves to PENDING.
- Simultaneous byte and flush in FILL: the byte is accepted first, then the flush applies.
  - If that byte completes the word, the result is a normal full word with no padding.
  - If the word was empty, the result is one byte plus three PAD_BYTE lanes.
- i_flush while in PENDING: ignored; the pending word is already complete.
- Reset mid-operation (any state, including PENDING with i_hold=1): the partial or pending word is discarded with no strobe; o_words_sent is cleared.
- o_fill_count reflects lanes filled in FILL; it reads 0 in PENDING.

Optional Feature:
Macro: TX_PACKER_TIMEOUT_EN
- Defined:
  - A 16-bit idle timer runs in FILL while lane count >0. It clears on any accepted byte and on leaving FILL.
  - When the timer reaches TIMEOUT_CLKS-1 without a byte, it acts as i_flush at that edge: pad and move to PENDING.
  - A byte accepted in the same cycle wins: the timer clears and no flush occurs.
- Not defined: no timer logic is present; partial words leave only via i_flush.

Test Plan:
- Reset, then bytes 8'hDE,8'hAD,8'hBE,8'hEF on 4 consecutive cycles, i_hold=0 -> o_word_write one cycle after the 4th, o_word_data=32'hDEADBEEF, o_words_sent=1, o_byte_ready low for exactly that cycle.
- Bytes 8'h11,8'h22 then i_flush, PAD_BYTE=8'h00 -> one strobe with 32'h11220000. A second i_flush with count 0 -> no strobe.
- Full word completed with i_hold=1 for 20 cycles -> no strobe and o_byte_ready=0 for 20 cycles. i_hold low -> one strobe, same data, then bytes accepted again.
- i_byte_valid=1 with 8'h44 and i_flush=1 in the same cycle, with 3 bytes 8'h11,8'h22,8'h33 held -> 32'h11223344, no padding, single strobe.
- i_reset asserted in PENDING with i_hold=1 -> no strobe ever for that word; o_fill_count=0, o_words_sent=0, o_byte_ready=1 the cycle after reset releases.
- With TX_PACKER_TIMEOUT_EN and TIMEOUT_CLKS=10: one byte 8'hA5, then idle -> strobe with 32'hA5000000 ~10 cycles later. A byte arriving at cycle 9 -> no timeout flush.
